// File: rtl/sram_req_adapter_if.sv
// sram_req_adapter_if: request/response stream bundle between an initiator and the SRAM request adapter.
interface sram_req_adapter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int AW         = 10
);
    localparam int BW = (DATA_WIDTH + 7) / 8;
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [AW-1:0]         req_addr_i;
    logic [BW-1:0]         req_be_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [USER_WIDTH-1:0] req_wuser_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_we_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic [USER_WIDTH-1:0] rsp_ruser_o;
    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, req_wuser_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_ruser_o
    );
    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_be_i, req_wdata_i, req_wuser_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_ruser_o
    );
endinterface

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready requests to a fixed-latency SRAM port, with a credit-protected response FIFO.
module sram_req_adapter #(
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 1,
    parameter int USER_EN      = 0,
    parameter int NUM_WORDS    = 1024,
    parameter int SRAM_LATENCY = 1,
    parameter int RSP_DEPTH    = 3,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    sram_req_adapter_if.slave     bus,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [BW-1:0]         sram_be_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [USER_WIDTH-1:0] sram_wuser_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic [USER_WIDTH-1:0] sram_ruser_i
);
    localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    logic [SRAM_LATENCY-1:0] pv_q, pw_q;
    logic [CW-1:0]           credit_q, credit_d, cnt_q, cnt_d;
    logic [PW-1:0]           wr_q, rd_q;
    logic                    we_q   [RSP_DEPTH];
    logic [DATA_WIDTH-1:0]   data_q [RSP_DEPTH];
    logic [USER_WIDTH-1:0]   user_q [RSP_DEPTH];
    logic                    accept, push, push_we, pop, empty;

    assign bus.req_ready_o = rst_ni && credit_q < CW'(RSP_DEPTH);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign sram_req_o      = accept;
    assign sram_we_o       = accept && bus.req_we_i;
    assign sram_addr_o     = bus.req_addr_i;
    assign sram_be_o       = bus.req_be_i;
    assign sram_wdata_o    = bus.req_wdata_i;
    assign sram_wuser_o    = bus.req_wuser_i;

    assign push            = pv_q[SRAM_LATENCY-1];
    assign push_we         = pw_q[SRAM_LATENCY-1];
    assign empty           = cnt_q == '0;
    assign bus.rsp_valid_o = rst_ni && !empty;
    assign pop             = bus.rsp_valid_o && bus.rsp_ready_i;
    assign bus.rsp_we_o    = !empty && we_q[rd_q];
    assign bus.rsp_rdata_o = empty ? '0 : data_q[rd_q];
    assign bus.rsp_ruser_o = empty ? '0 : user_q[rd_q];
    assign credit_d        = credit_q + CW'(accept) - CW'(pop);
    assign cnt_d           = cnt_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pv_q     <= '0;
            pw_q     <= '0;
            credit_q <= '0;
            cnt_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
        end else begin
            pv_q     <= (pv_q << 1) | SRAM_LATENCY'(accept);
            pw_q     <= (pw_q << 1) | SRAM_LATENCY'(accept && bus.req_we_i);
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            if (push) wr_q <= wr_q == PW'(RSP_DEPTH - 1) ? '0 : wr_q + 1'b1;
            if (pop) rd_q <= rd_q == PW'(RSP_DEPTH - 1) ? '0 : rd_q + 1'b1;
        end
    end

    // storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk_i) begin
        if (push) begin
            we_q[wr_q]   <= push_we;
            data_q[wr_q] <= push_we ? '0 : sram_rdata_i;
            user_q[wr_q] <= (push_we || USER_EN == 0) ? '0 : sram_ruser_i;
        end
    end
endmodule
